cart_mapper: RTL and testbench

Cartridge address mapper between the `cv_console` cartridge port and the SDRAM controller. It tracks the ROM download to learn the image size and detects MegaCart images. It translates CPU cartridge addresses into SDRAM byte addresses, including MegaCart bank switching. It also gates SDRAM read strobes while a download is in progress.

---
 rtl/cart_mapper_pkg.sv | 27 ++
 rtl/cart_mapper_edge_det.sv | 35 +++
 rtl/cart_mapper.sv | 159 +++++++++++++++
 tb/tb_cart_mapper.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_mapper_pkg.sv
// ============================================================================
// cart_mapper_pkg : shared types and constants for the cartridge mapper
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package cart_mapper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SIZE = 2'd2,
    RUN  = 2'd3
  } cm_state_t;

  localparam logic [15:0] HOTSPOT_BASE   = 16'hFFC0;
  localparam int          MEGA_MIN_PAGES = 2;
  localparam logic [15:0] FIXED_BASE     = 16'h8000;
  localparam logic [15:0] BANK_BASE      = 16'hC000;

  function automatic logic is_hotspot(input logic [15:0] addr);
    return addr >= HOTSPOT_BASE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cart_mapper_edge_det.sv
// ============================================================================
// edge_det : registered rise/fall detector with async active-low reset
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;
  logic armed;

  // armed stays low for the first cycle after reset so a level that is
  // already high at reset release is absorbed instead of reported as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      d_q   <= d;
      armed <= 1'b1;
    end
  end

  assign rise = armed &  d & ~d_q;
  assign fall = armed & ~d &  d_q;

endmodule

`default_nettype wire

// File: rtl/cart_mapper.sv
// ============================================================================
// cart_mapper : console cartridge address -> SDRAM byte address, with
//               download size tracking and MegaCart bank switching
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module cart_mapper
  import cart_mapper_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int PAGE_W = ADDR_W - 14
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              ioctl_download_i,
  input  logic              ioctl_wr_i,
  input  logic [24:0]       ioctl_addr_i,
  input  logic              sg1000_i,
  input  logic [15:0]       cart_a_i,
  input  logic              cart_rd_i,
  output logic [ADDR_W-1:0] cart_a_o,
  output logic              cart_rd_o,
  output logic [PAGE_W-1:0] cart_pages_o,
  output logic              megacart_o,
  output logic [PAGE_W-1:0] bank_o
);

  cm_state_t state;
  cm_state_t next_state;
  logic      enter_load;

  logic dl_rise;
  logic dl_fall;
  logic rd_rise;
  logic rd_fall;

  edge_det u_dl_det (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .d     (ioctl_download_i),
    .rise  (dl_rise),
    .fall  (dl_fall)
  );

  edge_det u_rd_det (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .d     (cart_rd_i),
    .rise  (rd_rise),
    .fall  (rd_fall)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    enter_load = 1'b0;
    case (state)
      IDLE: begin
        if (dl_rise) begin
          next_state = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        if (dl_fall) begin
          next_state = SIZE;
        end
      end
      SIZE: begin
        next_state = RUN;
      end
      RUN: begin
        if (dl_rise) begin
          next_state = LOAD;
          enter_load = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  logic mega_detect;
  logic hotspot_hit;

  assign mega_detect = !sg1000_i && (cart_pages_o >= PAGE_W'(MEGA_MIN_PAGES));
  assign hotspot_hit = (state == RUN) && megacart_o && rd_rise && is_hotspot(cart_a_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cart_pages_o <= '0;
      bank_o       <= '0;
      megacart_o   <= 1'b0;
    end else if (enter_load) begin
      cart_pages_o <= '0;
      bank_o       <= '0;
      megacart_o   <= 1'b0;
    end else begin
      // a write coinciding with the download falling edge still lands here,
      // because the state is still LOAD on that clock
      if ((state == LOAD) && ioctl_wr_i) begin
        cart_pages_o <= ioctl_addr_i[14 +: PAGE_W];
      end
      if (state == SIZE) begin
        megacart_o <= mega_detect;
        bank_o     <= '0;
      end
      // power-of-two images: masking with the last page index wraps the bank
      if (hotspot_hit) begin
        bank_o <= cart_a_i[PAGE_W-1:0] & cart_pages_o;
      end
    end
  end

  logic [ADDR_W-1:0] addr_map;

  always_comb begin
    addr_map = '0;
    if (sg1000_i) begin
      addr_map = ADDR_W'(cart_a_i);
    end else if (!megacart_o || (cart_a_i < FIXED_BASE)) begin
      addr_map = ADDR_W'(cart_a_i[14:0]);
    end else if (cart_a_i >= BANK_BASE) begin
      addr_map = {bank_o, cart_a_i[13:0]};
    end else begin
      addr_map = {cart_pages_o, cart_a_i[13:0]};
    end
  end

  // gating uses next_state so the registered strobe is low for every cycle
  // the mapper spends in LOAD or SIZE
  logic rd_gated;
  assign rd_gated = ((next_state == LOAD) || (next_state == SIZE)) ? 1'b0 : cart_rd_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cart_a_o  <= '0;
      cart_rd_o <= 1'b0;
    end else begin
      cart_a_o  <= addr_map;
      cart_rd_o <= rd_gated;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, rd_fall, ioctl_addr_i};

endmodule

`default_nettype wire

// File: tb/tb_cart_mapper.sv
// ============================================================================
// tb_cart_mapper : scoreboard-based self-checking bench for cart_mapper
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cart_mapper;
  import cart_mapper_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic        sg1000 = 1'b0;
  logic [15:0] cart_a = '0;
  logic        cart_rd = 1'b0;
  logic [19:0] cart_a_q;
  logic        cart_rd_q;
  logic [5:0]  cart_pages;
  logic        megacart;
  logic [5:0]  bank;

  cart_mapper #(.ADDR_W(20), .PAGE_W(6)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .ioctl_download_i (ioctl_download),
    .ioctl_wr_i       (ioctl_wr),
    .ioctl_addr_i     (ioctl_addr),
    .sg1000_i         (sg1000),
    .cart_a_i         (cart_a),
    .cart_rd_i        (cart_rd),
    .cart_a_o         (cart_a_q),
    .cart_rd_o        (cart_rd_q),
    .cart_pages_o     (cart_pages),
    .megacart_o       (megacart),
    .bank_o           (bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] a;
    logic        rd;
    logic [5:0]  b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // drive one cycle of console stimulus and queue what must appear one clock later
  task automatic drive(input logic [15:0] a, input logic rd,
                       input logic [19:0] ea, input logic erd, input logic [5:0] eb);
    exp_t e;
    @(negedge clk);
    cart_a  = a;
    cart_rd = rd;
    e.a = ea; e.rd = erd; e.b = eb;
    sb.push_back(e);
  endtask

  // full download: start, one early write, last write coinciding with the falling edge
  task automatic download(input logic [24:0] last);
    @(negedge clk);
    cart_rd = 1'b0;
    ioctl_download = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = '0;
    @(negedge clk);
    ioctl_addr = last; ioctl_download = 1'b0;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cart_rd = ~cart_rd;
      ioctl_download = ~ioctl_download;
      ioctl_wr = ~ioctl_wr;
      ioctl_addr = 25'($urandom);
      cart_a = 16'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (cart_rd_q !== 1'b0 || cart_a_q !== 20'h0) begin
        n_err++;
        $display("FAIL reset_out[%0d]: rd=%b a=%h, want rd=0 a=00000", i, cart_rd_q, cart_a_q);
      end
      n_cmp++;
      if ({cart_pages, megacart, bank} !== 13'h0 || dut.state !== IDLE) begin
        n_err++;
        $display("FAIL reset_state[%0d]: pages=%h mega=%b bank=%h state=%0d, want all 0/IDLE",
                 i, cart_pages, megacart, bank, dut.state);
      end
    end
    @(negedge clk);
    cart_rd = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; cart_a = '0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_coleco_32k();
    logic [15:0] at [4] = '{16'h9234, 16'h9234, 16'hFFC2, 16'h0000};
    logic        rt [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [19:0] et [4] = '{20'h01234, 20'h01234, 20'h07FC2, 20'h00000};
    exp_t e;
    sg1000 = 1'b0;
    download(25'h0007FFF);
    @(posedge clk); #1;
    n_cmp++;
    if (cart_pages !== 6'd1 || megacart !== 1'b0) begin
      n_err++;
      $display("FAIL coleco_size: pages=%0d mega=%b, want pages=1 mega=0", cart_pages, megacart);
    end
    for (int i = 0; i < 4; i++) begin
      drive(at[i], rt[i], et[i], rt[i], 6'd0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (cart_a_q !== e.a || cart_rd_q !== e.rd || bank !== e.b) begin
        n_err++;
        $display("FAIL coleco_read[%0d]: a=%h rd=%b bank=%0d, want a=%h rd=%b bank=%0d",
                 i, cart_a_q, cart_rd_q, bank, e.a, e.rd, e.b);
      end
    end
  endtask

  task automatic test_megacart_128k();
    logic [15:0] at [4] = '{16'h8005, 16'h8005, 16'hBFFF, 16'h0100};
    logic        rt [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [19:0] et [4] = '{20'h1C005, 20'h1C005, 20'h1FFFF, 20'h00100};
    exp_t e;
    download(25'h001FFFF);
    n_cmp++;
    if (megacart !== 1'b0) begin
      n_err++;
      $display("FAIL mega_early: mega=%b one clock after download end, want 0", megacart);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (megacart !== 1'b1 || cart_pages !== 6'd7) begin
      n_err++;
      $display("FAIL mega_size: mega=%b pages=%0d, want mega=1 pages=7", megacart, cart_pages);
    end
    for (int i = 0; i < 4; i++) begin
      drive(at[i], rt[i], et[i], rt[i], 6'd0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (cart_a_q !== e.a || cart_rd_q !== e.rd || bank !== e.b) begin
        n_err++;
        $display("FAIL mega_read[%0d]: a=%h rd=%b bank=%0d, want a=%h rd=%b bank=%0d",
                 i, cart_a_q, cart_rd_q, bank, e.a, e.rd, e.b);
      end
    end
  endtask

  task automatic test_bank_switch();
    logic [15:0] at [9] = '{16'hFFC3, 16'hFFC3, 16'hC010, 16'hC010, 16'hFFCA,
                            16'hFFCA, 16'hFFC5, 16'hFFC1, 16'h8005};
    logic        rt [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [19:0] et [9] = '{20'h03FC3, 20'h0FFC3, 20'h0C010, 20'h0C010, 20'h0FFCA,
                            20'h0BFCA, 20'h0BFC5, 20'h17FC1, 20'h1C005};
    logic [5:0]  bt [9] = '{6'd3, 6'd3, 6'd3, 6'd3, 6'd2, 6'd2, 6'd5, 6'd5, 6'd5};
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      drive(at[i], rt[i], et[i], rt[i], bt[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (cart_a_q !== e.a || cart_rd_q !== e.rd) begin
        n_err++;
        $display("FAIL bank_read[%0d]: a=%h rd=%b, want a=%h rd=%b", i, cart_a_q, cart_rd_q, e.a, e.rd);
      end
      n_cmp++;
      if (bank !== e.b) begin
        n_err++;
        $display("FAIL bank_value[%0d]: bank=%0d, want %0d", i, bank, e.b);
      end
    end
  endtask

  // new download straight out of RUN with a read held high throughout
  task automatic test_back_to_back();
    @(negedge clk);
    cart_a = 16'h8000; cart_rd = 1'b1; ioctl_download = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bank !== 6'd0 || megacart !== 1'b0 || cart_pages !== 6'd0 || cart_rd_q !== 1'b0) begin
      n_err++;
      $display("FAIL redl_clear: bank=%0d mega=%b pages=%0d rd=%b, want 0/0/0/0",
               bank, megacart, cart_pages, cart_rd_q);
    end
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = '0;
    @(posedge clk); #1;
    n_cmp++;
    if (cart_rd_q !== 1'b0) begin
      n_err++;
      $display("FAIL redl_gate_load: rd=%b, want 0", cart_rd_q);
    end
    @(negedge clk);
    ioctl_addr = 25'h0007FFF; ioctl_download = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (cart_rd_q !== 1'b0 || megacart !== 1'b0) begin
      n_err++;
      $display("FAIL redl_gate_size: rd=%b mega=%b, want rd=0 mega=0", cart_rd_q, megacart);
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (cart_rd_q !== 1'b1 || megacart !== 1'b0 || cart_pages !== 6'd1) begin
      n_err++;
      $display("FAIL redl_run: rd=%b mega=%b pages=%0d, want rd=1 mega=0 pages=1",
               cart_rd_q, megacart, cart_pages);
    end
    @(negedge clk);
    cart_rd = 1'b0;
  endtask

  task automatic test_sg1000_48k();
    logic [15:0] at [4] = '{16'hC123, 16'hFFC4, 16'hFFC4, 16'h0000};
    logic        rt [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [19:0] et [4] = '{20'h0C123, 20'h0FFC4, 20'h0FFC4, 20'h00000};
    exp_t e;
    sg1000 = 1'b1;
    download(25'h000BFFF);
    @(posedge clk); #1;
    n_cmp++;
    if (megacart !== 1'b0 || cart_pages !== 6'd2) begin
      n_err++;
      $display("FAIL sg_size: mega=%b pages=%0d, want mega=0 pages=2", megacart, cart_pages);
    end
    for (int i = 0; i < 4; i++) begin
      drive(at[i], rt[i], et[i], rt[i], 6'd0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (cart_a_q !== e.a || cart_rd_q !== e.rd || bank !== e.b) begin
        n_err++;
        $display("FAIL sg_read[%0d]: a=%h rd=%b bank=%0d, want a=%h rd=%b bank=%0d",
                 i, cart_a_q, cart_rd_q, bank, e.a, e.rd, e.b);
      end
    end
    sg1000 = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    exp_t e;
    @(negedge clk);
    ioctl_download = 1'b1; cart_rd = 1'b1; cart_a = 16'h1234;
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = 25'h001C000;
    @(negedge clk);
    ioctl_wr = 1'b0;
    n_cmp++;
    if (cart_pages !== 6'd7 || cart_rd_q !== 1'b0) begin
      n_err++;
      $display("FAIL midload_pre: pages=%0d rd=%b, want pages=7 rd=0", cart_pages, cart_rd_q);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (cart_pages !== 6'd0 || dut.state !== IDLE || cart_rd_q !== 1'b0 || cart_a_q !== 20'h0) begin
      n_err++;
      $display("FAIL midload_async: pages=%0d state=%0d rd=%b a=%h, want 0/IDLE/0/00000",
               cart_pages, dut.state, cart_rd_q, cart_a_q);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    drive(16'h1234, 1'b1, 20'h01234, 1'b1, 6'd0);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (cart_a_q !== e.a || cart_rd_q !== e.rd || dut.state !== IDLE) begin
      n_err++;
      $display("FAIL midload_nocapture: a=%h rd=%b state=%0d, want a=%h rd=%b state=IDLE",
               cart_a_q, cart_rd_q, dut.state, e.a, e.rd);
    end
    @(negedge clk);
    ioctl_download = 1'b0; cart_rd = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut.state !== IDLE) begin
      n_err++;
      $display("FAIL midload_fall: state=%0d, want IDLE", dut.state);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_coleco_32k();
    test_megacart_128k();
    test_bank_switch();
    test_back_to_back();
    test_sg1000_48k();
    test_reset_mid_load();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
